// File: rtl/uart_alu_pkg.sv
// ============================================================================
// Module  : uart_alu_pkg
// Purpose : Shared types and constants for the UART/ALU glue stage.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_alu_pkg;

  localparam int DBIT_DEF  = 8;
  localparam int NB_OP_DEF = 6;

  localparam logic [2:0] S_WAIT_A  = 3'd0;
  localparam logic [2:0] S_WAIT_B  = 3'd1;
  localparam logic [2:0] S_WAIT_OP = 3'd2;
  localparam logic [2:0] S_LOAD    = 3'd3;
  localparam logic [2:0] S_SEND    = 3'd4;
  localparam logic [2:0] S_WAIT_TX = 3'd5;

  typedef enum logic [2:0] {
    WAIT_A  = S_WAIT_A,
    WAIT_B  = S_WAIT_B,
    WAIT_OP = S_WAIT_OP,
    LOAD    = S_LOAD,
    SEND    = S_SEND,
    WAIT_TX = S_WAIT_TX
  } state_t;

  localparam logic [5:0] OP_ADD = 6'h20;
  localparam logic [5:0] OP_SUB = 6'h22;
  localparam logic [5:0] OP_AND = 6'h24;
  localparam logic [5:0] OP_OR  = 6'h25;
  localparam logic [5:0] OP_XOR = 6'h26;
  localparam logic [5:0] OP_NOR = 6'h27;
  localparam logic [5:0] OP_SRA = 6'h03;
  localparam logic [5:0] OP_SRL = 6'h02;

endpackage

`default_nettype wire

// File: rtl/uart_alu_interface_interbyte_timer.sv
// ============================================================================
// Module  : interbyte_timer
// Purpose : Gap counter between received bytes; pulses o_expire at TIMEOUT-1.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module interbyte_timer #(
  parameter int TIMEOUT = 1_000_000,
  parameter int NB_TO   = 20
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_en,
  input  logic i_clr,
  output logic o_expire
);

  localparam logic [NB_TO-1:0] LAST = NB_TO'(TIMEOUT - 1);

  logic [NB_TO-1:0] count_q;
  logic [NB_TO-1:0] count_d;
  logic             expire;

  // A clear in the expiry cycle suppresses the pulse: a fresh byte always wins.
  always_comb begin
    expire  = i_en && !i_clr && (count_q == LAST);
    count_d = count_q + 1'b1;
    if (!i_en || i_clr || expire) begin
      count_d = '0;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_expire = expire;

endmodule

`default_nettype wire

// File: rtl/uart_alu_interface.sv
// ============================================================================
// Module  : uart_alu_interface
// Purpose : Collects A, B, opcode bytes from UART RX, feeds the external ALU
//           and launches one TX frame with the result.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_alu_interface
  import uart_alu_pkg::*;
#(
  parameter int DBIT    = DBIT_DEF,
  parameter int NB_OP   = NB_OP_DEF,
  parameter int TIMEOUT = 1_000_000,
  parameter int NB_TO   = 20
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_rx_done,
  input  logic [DBIT-1:0]  i_rx_data,
  input  logic             i_tx_done,
  input  logic [DBIT-1:0]  i_alu_result,
  output logic [DBIT-1:0]  o_data_a,
  output logic [DBIT-1:0]  o_data_b,
  output logic [NB_OP-1:0] o_op,
  output logic             o_tx_start,
  output logic [DBIT-1:0]  o_tx_data,
  output logic             o_busy,
  output logic             o_timeout
);

  state_t            state_q, state_d;
  logic [DBIT-1:0]   data_a_q, data_a_d;
  logic [DBIT-1:0]   data_b_q, data_b_d;
  logic [NB_OP-1:0]  op_q, op_d;
  logic [DBIT-1:0]   tx_data_q, tx_data_d;
  logic              busy_q, busy_d;

  logic              timer_en;
  logic              timer_expire;
  logic              timeout;

  interbyte_timer #(
    .TIMEOUT (TIMEOUT),
    .NB_TO   (NB_TO)
  ) u_timer (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_en     (timer_en),
    .i_clr    (i_rx_done),
    .o_expire (timer_expire)
  );

  always_comb begin
    state_d   = state_q;
    data_a_d  = data_a_q;
    data_b_d  = data_b_q;
    op_d      = op_q;
    tx_data_d = tx_data_q;
    busy_d    = busy_q;
    timeout   = 1'b0;
    timer_en  = (state_q == WAIT_B) || (state_q == WAIT_OP);

    case (state_q)
      WAIT_A: begin
        if (i_rx_done) begin
          data_a_d = i_rx_data;
          state_d  = WAIT_B;
        end
      end
      WAIT_B: begin
        if (i_rx_done) begin
          data_b_d = i_rx_data;
          state_d  = WAIT_OP;
        end else if (timer_expire) begin
          timeout = 1'b1;
          state_d = WAIT_A;
        end
      end
      WAIT_OP: begin
        if (i_rx_done) begin
          op_d    = i_rx_data[NB_OP-1:0];
          busy_d  = 1'b1;
          state_d = LOAD;
        end else if (timer_expire) begin
          timeout = 1'b1;
          state_d = WAIT_A;
        end
      end
      // Operands became visible to the ALU at the start of this cycle.
      LOAD: begin
        tx_data_d = i_alu_result;
        state_d   = SEND;
      end
      SEND: begin
        state_d = WAIT_TX;
      end
      WAIT_TX: begin
        if (i_tx_done) begin
          busy_d  = 1'b0;
          state_d = WAIT_A;
        end
      end
      default: begin
        state_d = WAIT_A;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q   <= WAIT_A;
      data_a_q  <= '0;
      data_b_q  <= '0;
      op_q      <= '0;
      tx_data_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_a_q  <= data_a_d;
      data_b_q  <= data_b_d;
      op_q      <= op_d;
      tx_data_q <= tx_data_d;
      busy_q    <= busy_d;
    end
  end

  assign o_data_a   = data_a_q;
  assign o_data_b   = data_b_q;
  assign o_op       = op_q;
  assign o_tx_data  = tx_data_q;
  assign o_busy     = busy_q;
  assign o_tx_start = (state_q == SEND);
  assign o_timeout  = timeout;

endmodule

`default_nettype wire

// File: tb/tb_uart_alu_interface.sv
// ============================================================================
// Module  : tb_uart_alu_interface
// Purpose : Scoreboard bench for uart_alu_interface with a behavioural ALU.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_alu_interface;
  import uart_alu_pkg::*;

  logic       clk;
  logic       i_reset;
  logic       i_rx_done;
  logic [7:0] i_rx_data;
  logic       i_tx_done;
  logic [7:0] alu_res;
  logic [7:0] o_data_a;
  logic [7:0] o_data_b;
  logic [5:0] o_op;
  logic       o_tx_start;
  logic [7:0] o_tx_data;
  logic       o_busy;
  logic       o_timeout;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] op;
    logic [7:0] tx;
  } exp_t;

  exp_t exp_q[$];
  int   to_q[$];

  uart_alu_interface #(
    .DBIT    (8),
    .NB_OP   (6),
    .TIMEOUT (100),
    .NB_TO   (20)
  ) dut (
    .i_clock      (clk),
    .i_reset      (i_reset),
    .i_rx_done    (i_rx_done),
    .i_rx_data    (i_rx_data),
    .i_tx_done    (i_tx_done),
    .i_alu_result (alu_res),
    .o_data_a     (o_data_a),
    .o_data_b     (o_data_b),
    .o_op         (o_op),
    .o_tx_start   (o_tx_start),
    .o_tx_data    (o_tx_data),
    .o_busy       (o_busy),
    .o_timeout    (o_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // External combinational ALU
  always_comb begin
    alu_res = 8'h00;
    case (o_op)
      OP_ADD:  alu_res = o_data_a + o_data_b;
      OP_SUB:  alu_res = o_data_a - o_data_b;
      OP_AND:  alu_res = o_data_a & o_data_b;
      OP_OR:   alu_res = o_data_a | o_data_b;
      OP_XOR:  alu_res = o_data_a ^ o_data_b;
      OP_NOR:  alu_res = ~(o_data_a | o_data_b);
      OP_SRA:  alu_res = 8'($signed(o_data_a) >>> o_data_b);
      OP_SRL:  alu_res = o_data_a >> o_data_b;
      default: alu_res = 8'h00;
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every TX request and every timeout pulse must be anticipated.
  always @(negedge clk) begin
    if (o_tx_start) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_tx_start", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("tx_data", {24'd0, o_tx_data}, {24'd0, e.tx});
        chk("data_a", {24'd0, o_data_a}, {24'd0, e.a});
        chk("data_b", {24'd0, o_data_b}, {24'd0, e.b});
        chk("op", {26'd0, o_op}, {26'd0, e.op});
      end
    end
    if (o_timeout) begin
      if (to_q.size() == 0) begin
        chk("unexpected_timeout", 32'd1, 32'd0);
      end else begin
        int ec;
        ec = to_q.pop_front();
        chk("timeout_cycle", cyc, ec);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rx(input logic [7:0] b);
    i_rx_data = b;
    i_rx_done = 1'b1;
    tick();
    i_rx_done = 1'b0;
    i_rx_data = 8'h00;
  endtask

  task automatic send_set(input logic [7:0] a, input logic [7:0] b,
                          input logic [5:0] op, input logic [7:0] tx);
    exp_t e;
    e.a = a; e.b = b; e.op = op; e.tx = tx;
    exp_q.push_back(e);
    rx(a);
    rx(b);
    rx({2'b00, op});
    @(negedge clk);
    chk("busy_rise", {31'd0, o_busy}, 32'd1);
    chk("start_early", {31'd0, o_tx_start}, 32'd0);
    tick();
    @(negedge clk);
    chk("start_latency", {31'd0, o_tx_start}, 32'd1);
    tick();
  endtask

  task automatic finish_tx(input logic [7:0] a, input logic [7:0] tx, input logic inject);
    repeat (3) tick();
    @(negedge clk);
    chk("busy_hold", {31'd0, o_busy}, 32'd1);
    if (inject) begin
      tick();
      rx(8'h55);
      @(negedge clk);
      chk("inject_data_a", {24'd0, o_data_a}, {24'd0, a});
      chk("inject_tx_data", {24'd0, o_tx_data}, {24'd0, tx});
      chk("inject_busy", {31'd0, o_busy}, 32'd1);
    end
    tick();
    i_tx_done = 1'b1;
    tick();
    i_tx_done = 1'b0;
    @(negedge clk);
    chk("busy_fall", {31'd0, o_busy}, 32'd0);
    chk("tx_data_held", {24'd0, o_tx_data}, {24'd0, tx});
    tick();
  endtask

  task automatic check_zero(input string nm);
    @(negedge clk);
    chk({nm, "_a"}, {24'd0, o_data_a}, 32'd0);
    chk({nm, "_b"}, {24'd0, o_data_b}, 32'd0);
    chk({nm, "_op"}, {26'd0, o_op}, 32'd0);
    chk({nm, "_tx_data"}, {24'd0, o_tx_data}, 32'd0);
    chk({nm, "_busy"}, {31'd0, o_busy}, 32'd0);
    chk({nm, "_start"}, {31'd0, o_tx_start}, 32'd0);
    chk({nm, "_timeout"}, {31'd0, o_timeout}, 32'd0);
  endtask

  task automatic pulse_reset();
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
  endtask

  initial begin
    int c1;
    i_reset   = 1'b1;
    i_rx_done = 1'b0;
    i_rx_data = 8'h00;
    i_tx_done = 1'b0;
    tick();
    tick();
    i_reset = 1'b0;
    check_zero("reset");
    tick();

    // Normal frame, then back-to-back sets
    send_set(8'h14, 8'h07, OP_ADD, 8'h1B);
    finish_tx(8'h14, 8'h1B, 1'b0);
    send_set(8'h14, 8'h07, OP_SUB, 8'h0D);
    finish_tx(8'h14, 8'h0D, 1'b0);
    send_set(8'hF0, 8'h0F, OP_OR, 8'hFF);
    finish_tx(8'hF0, 8'hFF, 1'b0);

    // Partial set expires 100 cycles after the lone byte
    rx(8'h14);
    c1 = cyc;
    to_q.push_back(c1 + 99);
    repeat (98) tick();
    @(negedge clk);
    chk("timeout_not_yet", {31'd0, o_timeout}, 32'd0);
    tick();
    @(negedge clk);
    chk("timeout_pulse", {31'd0, o_timeout}, 32'd1);
    chk("timeout_stale_a", {24'd0, o_data_a}, 32'h14);
    tick();
    @(negedge clk);
    chk("timeout_one_cycle", {31'd0, o_timeout}, 32'd0);
    send_set(8'h03, 8'h04, OP_ADD, 8'h07);
    finish_tx(8'h03, 8'h07, 1'b0);

    // Stray byte while waiting for TX completion
    send_set(8'h09, 8'h06, OP_AND, 8'h00);
    finish_tx(8'h09, 8'h00, 1'b1);
    send_set(8'hA5, 8'h0F, OP_XOR, 8'hAA);
    finish_tx(8'hA5, 8'hAA, 1'b0);

    // Reset while in WAIT_TX
    send_set(8'h80, 8'h02, OP_SRA, 8'hE0);
    tick();
    pulse_reset();
    check_zero("rst_wait_tx");
    repeat (4) tick();

    // Reset while in WAIT_OP
    rx(8'h11);
    rx(8'h22);
    pulse_reset();
    check_zero("rst_wait_op");
    repeat (4) tick();
    send_set(8'h09, 8'h03, OP_SRL, 8'h01);
    finish_tx(8'h09, 8'h01, 1'b0);

    // Byte arriving on the expiry cycle is accepted as operand B
    rx(8'h30);
    repeat (99) tick();
    rx(8'h05);
    @(negedge clk);
    chk("coinc_data_b", {24'd0, o_data_b}, 32'h05);
    chk("coinc_data_a", {24'd0, o_data_a}, 32'h30);
    tick();
    begin
      exp_t e;
      e.a = 8'h30; e.b = 8'h05; e.op = OP_SUB; e.tx = 8'h2B;
      exp_q.push_back(e);
    end
    rx({2'b00, OP_SUB});
    @(negedge clk);
    chk("coinc_busy", {31'd0, o_busy}, 32'd1);
    tick();
    @(negedge clk);
    chk("coinc_start", {31'd0, o_tx_start}, 32'd1);
    tick();
    finish_tx(8'h30, 8'h2B, 1'b0);

    repeat (3) tick();
    chk("tx_queue_drained", exp_q.size(), 32'd0);
    chk("timeout_queue_drained", to_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_alu_interface.md
Name: uart_alu_interface

Overview:
- Glue stage between the UART receiver and transmitter in the UART/ALU top level.
- Collects three bytes from the RX path in order: operand A, operand B, opcode.
- Presents them registered to the combinational ALU, captures the ALU result, and launches one TX frame with it.
- Runs an inter-byte timeout so a lost or partial frame resynchronises to "expect A".

Parameters:
- DBIT, 8, data/operand byte width.
- NB_OP, 6, opcode width; low NB_OP bits of the opcode byte are used.
- TIMEOUT, 1_000_000, max clock cycles allowed between consecutive received bytes of one frame set.
- NB_TO, 20, timeout counter width; must satisfy 2**NB_TO > TIMEOUT.

Ports:
- i_clock  in  1  system clock; single clock domain.
- i_reset  in  1  synchronous, active-high reset.
- i_rx_done  in  1  one-cycle pulse from UART RX; i_rx_data is valid in that cycle.
- i_rx_data  in  DBIT  received byte.
- i_tx_done  in  1  one-cycle pulse from UART TX when the stop bit has finished.
- i_alu_result  in  DBIT  combinational ALU output for o_data_a/o_data_b/o_op.
- o_data_a  out  DBIT  registered operand A to ALU.
- o_data_b  out  DBIT  registered operand B to ALU.
- o_op  out  NB_OP  registered opcode to ALU.
- o_tx_start  out  1  one-cycle pulse requesting TX of o_tx_data.
- o_tx_data  out  DBIT  byte to transmit; held stable until i_tx_done.
- o_busy  out  1  high from opcode capture until i_tx_done.
- o_timeout  out  1  one-cycle pulse when a partial set is discarded.

Behaviour:
- Reset (sampled on rising i_clock with i_reset=1):
  - State is WAIT_A.
  - All data outputs are 0; o_tx_start, o_busy and o_timeout are 0.
  - Timeout counter is 0.
  - Reset has priority over every other event, including mid-TX; any pending TX request is abandoned.
- FSM states: WAIT_A, WAIT_B, WAIT_OP, LOAD, SEND, WAIT_TX.
- WAIT_A: on i_rx_done, o_data_a <= i_rx_data, go to WAIT_B.
- WAIT_B: on i_rx_done, o_data_b <= i_rx_data, go to WAIT_OP.
- WAIT_OP: on i_rx_done, o_op <= i_rx_data[NB_OP-1:0], o_busy <= 1, go to LOAD.
- LOAD: one cycle for the ALU to settle on the new registered operands. o_tx_data <= i_alu_result; go to SEND.
- SEND: o_tx_start = 1 for exactly this cycle; go to WAIT_TX.
- WAIT_TX: on i_tx_done, o_busy <= 0, go to WAIT_A. o_tx_data is unchanged.
- Latency: the opcode i_rx_done is in cycle N. o_busy rises in N+1. o_tx_data is valid from N+2. o_tx_start is high in cycle N+2.
- Timeout:
  - The counter runs only in WAIT_B and WAIT_OP, and clears on every i_rx_done.
  - When it reaches TIMEOUT-1 without an i_rx_done: go to WAIT_A, pulse o_timeout for 1 cycle, clear the counter.
  - o_data_a and o_data_b keep their stale values.
  - If i_rx_done and expiry coincide, the byte wins: it is accepted and the counter clears.
- i_rx_done in LOAD, SEND or WAIT_TX: the byte is dropped and not queued. No state change.
- i_tx_done outside WAIT_TX is ignored.
- Operand registers change only on their capture event, never combinationally from i_rx_data.

Decomposition:
- Shared package uart_alu_pkg holds:
  - FSM state encoding (localparams, 3 bits).
  - Opcode constants: ADD 6'h20, SUB 6'h22, AND 6'h24, OR 6'h25, XOR 6'h26, NOR 6'h27, SRA 6'h03, SRL 6'h02.
  - Default DBIT and NB_OP.
- One natural sub-module: interbyte_timer (counter with clear, enable, and expiry pulse). Everything else stays in the FSM module.
- The ALU stays external.

Test Plan:
- Normal frame: rx bytes 0x14, 0x07, 0x20 (ADD), ALU model returns 0x1B. Expect:
  - o_data_a=0x14, o_data_b=0x07, o_op=6'h20.
  - o_tx_start pulse 2 cycles after the opcode i_rx_done, with o_tx_data=0x1B.
  - o_busy high until i_tx_done, then state WAIT_A.
- Back-to-back sets: 0x14, 0x07, SUB 0x22 -> TX 0x0D; after i_tx_done, 0xF0, 0x0F, OR 0x25 -> TX 0xFF. Expect exactly one o_tx_start per set.
- Timeout: send 0x14 only, then idle TIMEOUT cycles (TIMEOUT=100 in bench). Expect:
  - o_timeout pulse at cycle 100 after the byte.
  - Next bytes 0x03, 0x04, ADD -> TX 0x07 (0x03 is taken as A).
- Byte during WAIT_TX: inject i_rx_done with 0x55 before i_tx_done. Expect no change to o_data_a or o_tx_data; the following set is processed from A.
- Reset mid-operation: assert i_reset in WAIT_TX and in WAIT_OP. Expect all outputs 0 next cycle and no o_tx_start; a subsequent full set works.
- Coincident expiry and byte: i_rx_done on the expiry cycle. Expect no o_timeout and the byte is accepted into the next field.
